addr_src_mux: RTL and testbench



---
 rtl/addr_mux_pkg.sv | 19 +
 rtl/addr_out_reg.sv | 46 ++++
 rtl/addr_src_mux.sv | 173 +++++++++++++++++
 tb/tb_addr_src_mux.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/addr_mux_pkg.sv
// Shared definitions for the address source multiplexer and its output stage.
// Holds the switch FSM encoding, the gap counter width and the select-width helper.
// No logic; imported by addr_src_mux and addr_out_reg.
package addr_mux_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    GAP   = 2'd2
  } mux_state_e;

  localparam int GAP_CNT_W = 4;

  // A single-source mux still needs a 1-bit select to keep port widths legal.
  function automatic int sel_width(input int num_src);
    return (num_src > 1) ? $clog2(num_src) : 1;
  endfunction

endpackage

// File: rtl/addr_out_reg.sv
// Single-stage valid/ready register, full throughput, reusable by any generator.
// Latency: 1 cycle from in_dat accept to out_dat.
// Backpressure: in_rdy = ~out_vld | out_rdy; data holds while out_vld & ~out_rdy.
// Ports: in_dat/in_vld/in_rdy upstream side, out_dat/out_vld/out_rdy downstream side.
module addr_out_reg #(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_dat,
  input  logic         in_vld,
  output logic         in_rdy,
  output logic [W-1:0] out_dat,
  output logic         out_vld,
  input  logic         out_rdy
);

  logic [W-1:0] dat_q, dat_d;
  logic         vld_q, vld_d;

  assign in_rdy  = ~vld_q | out_rdy;
  assign out_dat = dat_q;
  assign out_vld = vld_q;

  always_comb begin
    dat_d = dat_q;
    vld_d = vld_q;
    if (in_vld && in_rdy) begin
      dat_d = in_dat;
      vld_d = 1'b1;
    end else if (out_rdy) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dat_q <= '0;
      vld_q <= 1'b0;
    end else begin
      dat_q <= dat_d;
      vld_q <= vld_d;
    end
  end

endmodule

// File: rtl/addr_src_mux.sv
// Registered NUM_SRC:1 address mux with drain-before-switch source change.
// Latency: 1 cycle src -> addr_out; a switch drains the output register, idles GAP_CYCLES, then acks.
// Backpressure: only the committed source sees src_ready (= ~addr_valid | addr_ready); all stall during a switch.
// Ports: src_addr/src_valid/src_ready sources; sel_req/sel_next/sel_ack/sel_err/sel_cur switch control;
//        addr_out/addr_valid/addr_ready output stream; addr_par only when ADDR_SRC_MUX_PARITY_EN is defined.
module addr_src_mux
  import addr_mux_pkg::*;
#(
  parameter int ADDR_W     = 14,
  parameter int NUM_SRC    = 4,
  parameter int SEL_W      = sel_width(NUM_SRC),
  parameter int GAP_CYCLES = 1,
  parameter int RESET_SEL  = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic                      sel_req,
  input  logic [SEL_W-1:0]          sel_next,
  output logic                      sel_ack,
  output logic                      sel_err,
  output logic [SEL_W-1:0]          sel_cur,
  output logic [ADDR_W-1:0]         addr_out,
  output logic                      addr_valid,
  input  logic                      addr_ready
`ifdef ADDR_SRC_MUX_PARITY_EN
  ,
  output logic                      addr_par
`endif
);

`ifdef ADDR_SRC_MUX_PARITY_EN
  localparam int DAT_W = ADDR_W + 1;
`else
  localparam int DAT_W = ADDR_W;
`endif

  mux_state_e             state_q, state_d;
  logic [SEL_W-1:0]       sel_cur_q, sel_cur_d;
  logic [SEL_W-1:0]       pend_q, pend_d;
  logic [GAP_CNT_W-1:0]   cnt_q, cnt_d;
  logic                   ack_q, ack_d;
  logic                   err_q, err_d;

  logic [ADDR_W-1:0]      cur_addr;
  logic                   cur_vld;
  logic                   run;
  logic                   reg_in_rdy;
  logic                   reg_in_vld;
  logic [DAT_W-1:0]       reg_in_dat;
  logic [DAT_W-1:0]       reg_out_dat;
  logic                   req_oor;

  assign run     = (state_q == RUN);
  assign req_oor = (int'(sel_next) >= NUM_SRC);

  // Source select by loop compare keeps index arithmetic width-clean.
  always_comb begin
    cur_addr = '0;
    cur_vld  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (sel_cur_q == SEL_W'(i)) begin
        cur_addr = src_addr[i*ADDR_W +: ADDR_W];
        cur_vld  = src_valid[i];
      end
    end
  end

  // rst_n gating holds every src_ready low while reset is asserted.
  always_comb begin
    src_ready = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (sel_cur_q == SEL_W'(i)) src_ready[i] = rst_n & run & reg_in_rdy;
    end
  end

  assign reg_in_vld = run & cur_vld;

`ifdef ADDR_SRC_MUX_PARITY_EN
  // Parity rides in the top bit of the register so it stays aligned with the address.
  assign reg_in_dat = {^cur_addr, cur_addr};
  assign addr_par   = reg_out_dat[ADDR_W];
`else
  assign reg_in_dat = cur_addr;
`endif
  assign addr_out = reg_out_dat[ADDR_W-1:0];

  addr_out_reg #(
    .W (DAT_W)
  ) u_out_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_dat  (reg_in_dat),
    .in_vld  (reg_in_vld),
    .in_rdy  (reg_in_rdy),
    .out_dat (reg_out_dat),
    .out_vld (addr_valid),
    .out_rdy (addr_ready)
  );

  // Switch FSM. reg_in_rdy doubles as "output register empty by the next edge".
  always_comb begin
    state_d   = state_q;
    sel_cur_d = sel_cur_q;
    pend_d    = pend_q;
    cnt_d     = cnt_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      RUN: begin
        if (sel_req) begin
          if (req_oor) begin
            err_d = 1'b1;
          end else if (sel_next == sel_cur_q) begin
            ack_d = 1'b1;
          end else begin
            pend_d  = sel_next;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (reg_in_rdy) begin
          if (GAP_CYCLES == 0) begin
            sel_cur_d = pend_q;
            ack_d     = 1'b1;
            state_d   = RUN;
          end else begin
            cnt_d   = GAP_CNT_W'(GAP_CYCLES);
            state_d = GAP;
          end
        end
      end
      GAP: begin
        // Commit on the cycle the count would reach zero: exactly GAP_CYCLES idle cycles.
        if (cnt_q <= GAP_CNT_W'(1)) begin
          cnt_d     = '0;
          sel_cur_d = pend_q;
          ack_d     = 1'b1;
          state_d   = RUN;
        end else begin
          cnt_d = cnt_q - GAP_CNT_W'(1);
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      sel_cur_q <= SEL_W'(RESET_SEL);
      pend_q    <= '0;
      cnt_q     <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_cur_q <= sel_cur_d;
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
    end
  end

  assign sel_ack = ack_q;
  assign sel_err = err_q;
  assign sel_cur = sel_cur_q;

endmodule

// File: tb/tb_addr_src_mux.sv
module tb_addr_src_mux;

  localparam int AW = 14;

  logic          clk;
  logic          rst_n;

  // Main instance: NUM_SRC=4, GAP_CYCLES=1, RESET_SEL=0.
  logic [4*AW-1:0] src_addr;
  logic [3:0]      src_valid;
  logic [3:0]      src_ready;
  logic            sel_req;
  logic [1:0]      sel_next;
  logic            sel_ack;
  logic            sel_err;
  logic [1:0]      sel_cur;
  logic [AW-1:0]   addr_out;
  logic            addr_valid;
  logic            addr_ready;

  // Second instance: NUM_SRC=3 so an out-of-range index is representable.
  logic [3*AW-1:0] src_addr3;
  logic [2:0]      src_valid3;
  logic [2:0]      src_ready3;
  logic            sel_req3;
  logic [1:0]      sel_next3;
  logic            sel_ack3;
  logic            sel_err3;
  logic [1:0]      sel_cur3;
  logic [AW-1:0]   addr_out3;
  logic            addr_valid3;
  logic            addr_ready3;

`ifdef ADDR_SRC_MUX_PARITY_EN
  logic            addr_par;
  logic            addr_par3;
`endif

  int vec_cnt;
  int err_cnt;

  addr_src_mux #(
    .ADDR_W(AW), .NUM_SRC(4), .GAP_CYCLES(1), .RESET_SEL(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .src_addr(src_addr), .src_valid(src_valid),
    .src_ready(src_ready), .sel_req(sel_req), .sel_next(sel_next),
    .sel_ack(sel_ack), .sel_err(sel_err), .sel_cur(sel_cur),
    .addr_out(addr_out), .addr_valid(addr_valid), .addr_ready(addr_ready)
`ifdef ADDR_SRC_MUX_PARITY_EN
    , .addr_par(addr_par)
`endif
  );

  addr_src_mux #(
    .ADDR_W(AW), .NUM_SRC(3), .GAP_CYCLES(1), .RESET_SEL(0)
  ) dut3 (
    .clk(clk), .rst_n(rst_n), .src_addr(src_addr3), .src_valid(src_valid3),
    .src_ready(src_ready3), .sel_req(sel_req3), .sel_next(sel_next3),
    .sel_ack(sel_ack3), .sel_err(sel_err3), .sel_cur(sel_cur3),
    .addr_out(addr_out3), .addr_valid(addr_valid3), .addr_ready(addr_ready3)
`ifdef ADDR_SRC_MUX_PARITY_EN
    , .addr_par(addr_par3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    src_addr = '0; src_valid = '0; sel_req = 1'b0; sel_next = '0; addr_ready = 1'b0;
    src_addr3 = '0; src_valid3 = '0; sel_req3 = 1'b0; sel_next3 = '0; addr_ready3 = 1'b0;
    #3;
    vec_cnt++; if (sel_cur !== 2'd0) begin err_cnt++; $display("FAIL reset_sel_cur got %0d want 0", sel_cur); end
    vec_cnt++; if (addr_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_addr_valid got %b want 0", addr_valid); end
    vec_cnt++; if (addr_out !== 14'h0) begin err_cnt++; $display("FAIL reset_addr_out got %h want 0", addr_out); end
    vec_cnt++; if (src_ready !== 4'b0000) begin err_cnt++; $display("FAIL reset_src_ready got %b want 0000", src_ready); end
    vec_cnt++; if ({sel_ack, sel_err} !== 2'b00) begin err_cnt++; $display("FAIL reset_ack_err got %b want 00", {sel_ack, sel_err}); end
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_first_load();
    src_addr[0*AW +: AW] = 14'h0123;
    src_addr[1*AW +: AW] = 14'h1111;
    src_addr[2*AW +: AW] = 14'h2222;
    src_addr[3*AW +: AW] = 14'h3333;
    src_valid = 4'b1111;
    addr_ready = 1'b1;
    #1;
    vec_cnt++; if (src_ready !== 4'b0001) begin err_cnt++; $display("FAIL first_src_ready got %b want 0001", src_ready); end
    step();
    vec_cnt++; if (addr_out !== 14'h0123 || addr_valid !== 1'b1) begin err_cnt++; $display("FAIL first_load got %h/%b want 0123/1", addr_out, addr_valid); end
    src_valid = 4'b0001;
  endtask

  task automatic test_stream();
    for (int i = 0; i < 16; i++) begin
      src_addr[0*AW +: AW] = AW'(i);
      step();
      vec_cnt++; if (addr_out !== AW'(i) || addr_valid !== 1'b1) begin err_cnt++; $display("FAIL stream_%0d got %h/%b want %h/1", i, addr_out, addr_valid, i); end
    end
    addr_ready = 1'b0;
    src_addr[0*AW +: AW] = 14'h03AA;
    #1;
    vec_cnt++; if (src_ready !== 4'b0000) begin err_cnt++; $display("FAIL stall_src_ready got %b want 0000", src_ready); end
    for (int i = 0; i < 3; i++) begin
      step();
      vec_cnt++; if (addr_out !== 14'h000F || addr_valid !== 1'b1 || src_ready !== 4'b0000) begin
        err_cnt++; $display("FAIL hold_%0d got %h/%b/%b want 000f/1/0000", i, addr_out, addr_valid, src_ready);
      end
    end
    addr_ready = 1'b1;
    #1;
    vec_cnt++; if (src_ready !== 4'b0001) begin err_cnt++; $display("FAIL unstall_src_ready got %b want 0001", src_ready); end
    step();
    vec_cnt++; if (addr_out !== 14'h03AA) begin err_cnt++; $display("FAIL after_stall got %h want 03aa", addr_out); end
  endtask

  task automatic test_switch();
    src_addr[0*AW +: AW] = 14'h0100;
    src_addr[2*AW +: AW] = 14'h2200;
    src_valid = 4'b0101;
    sel_req = 1'b1; sel_next = 2'd2;
    step();
    vec_cnt++; if (addr_out !== 14'h0100 || addr_valid !== 1'b1) begin err_cnt++; $display("FAIL sw_last_old got %h/%b want 0100/1", addr_out, addr_valid); end
    sel_req = 1'b0; addr_ready = 1'b0;
    src_addr[0*AW +: AW] = 14'h0101;
    #1;
    vec_cnt++; if (src_ready !== 4'b0000) begin err_cnt++; $display("FAIL sw_drain_ready got %b want 0000", src_ready); end
    step();
    step();
    vec_cnt++; if (addr_out !== 14'h0100 || addr_valid !== 1'b1 || src_ready !== 4'b0000 || sel_ack !== 1'b0) begin
      err_cnt++; $display("FAIL sw_drain_hold got %h/%b/%b/%b want 0100/1/0000/0", addr_out, addr_valid, src_ready, sel_ack);
    end
    addr_ready = 1'b1;
    step();
    vec_cnt++; if (addr_valid !== 1'b0 || sel_ack !== 1'b0 || sel_cur !== 2'd0 || src_ready !== 4'b0000) begin
      err_cnt++; $display("FAIL sw_gap got vld=%b ack=%b cur=%0d rdy=%b want 0/0/0/0000", addr_valid, sel_ack, sel_cur, src_ready);
    end
    step();
    vec_cnt++; if (sel_ack !== 1'b1 || sel_cur !== 2'd2 || src_ready !== 4'b0100 || addr_valid !== 1'b0) begin
      err_cnt++; $display("FAIL sw_commit got ack=%b cur=%0d rdy=%b vld=%b want 1/2/0100/0", sel_ack, sel_cur, src_ready, addr_valid);
    end
    step();
    vec_cnt++; if (sel_ack !== 1'b0 || addr_out !== 14'h2200 || addr_valid !== 1'b1) begin
      err_cnt++; $display("FAIL sw_new_src got ack=%b %h/%b want 0 2200/1", sel_ack, addr_out, addr_valid);
    end
  endtask

  task automatic test_same_sel();
    src_addr[2*AW +: AW] = 14'h2201;
    sel_req = 1'b1; sel_next = 2'd2;
    step();
    vec_cnt++; if (sel_ack !== 1'b1 || sel_cur !== 2'd2 || addr_out !== 14'h2201) begin
      err_cnt++; $display("FAIL same_ack got ack=%b cur=%0d out=%h want 1/2/2201", sel_ack, sel_cur, addr_out);
    end
    sel_req = 1'b0;
    src_addr[2*AW +: AW] = 14'h2202;
    #1;
    vec_cnt++; if (src_ready !== 4'b0100) begin err_cnt++; $display("FAIL same_no_stall got %b want 0100", src_ready); end
    step();
    vec_cnt++; if (sel_ack !== 1'b0 || addr_out !== 14'h2202 || addr_valid !== 1'b1) begin
      err_cnt++; $display("FAIL same_next got ack=%b %h/%b want 0 2202/1", sel_ack, addr_out, addr_valid);
    end
  endtask

  task automatic test_err();
    src_addr3[0*AW +: AW] = 14'h0555;
    src_valid3 = 3'b001; addr_ready3 = 1'b1;
    sel_req3 = 1'b1; sel_next3 = 2'd3;
    step();
    vec_cnt++; if (sel_err3 !== 1'b1 || sel_ack3 !== 1'b0 || sel_cur3 !== 2'd0) begin
      err_cnt++; $display("FAIL err_pulse got err=%b ack=%b cur=%0d want 1/0/0", sel_err3, sel_ack3, sel_cur3);
    end
    vec_cnt++; if (addr_out3 !== 14'h0555 || addr_valid3 !== 1'b1) begin err_cnt++; $display("FAIL err_load got %h/%b want 0555/1", addr_out3, addr_valid3); end
    sel_req3 = 1'b0;
    src_addr3[0*AW +: AW] = 14'h0556;
    #1;
    vec_cnt++; if (src_ready3 !== 3'b001) begin err_cnt++; $display("FAIL err_no_stall got %b want 001", src_ready3); end
    step();
    vec_cnt++; if (sel_err3 !== 1'b0 || addr_out3 !== 14'h0556) begin err_cnt++; $display("FAIL err_after got err=%b out=%h want 0/0556", sel_err3, addr_out3); end
  endtask

  task automatic test_reset_in_gap();
    src_addr[2*AW +: AW] = 14'h2300;
    sel_req = 1'b1; sel_next = 2'd1;
    step();
    sel_req = 1'b0;
    step();
    vec_cnt++; if (addr_valid !== 1'b0 || sel_cur !== 2'd2 || sel_ack !== 1'b0) begin
      err_cnt++; $display("FAIL gap_entry got vld=%b cur=%0d ack=%b want 0/2/0", addr_valid, sel_cur, sel_ack);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vec_cnt++; if (sel_cur !== 2'd0 || addr_out !== 14'h0 || addr_valid !== 1'b0 || src_ready !== 4'b0000) begin
      err_cnt++; $display("FAIL async_reset got cur=%0d out=%h vld=%b rdy=%b want 0/0000/0/0000", sel_cur, addr_out, addr_valid, src_ready);
    end
    src_valid = 4'b0000;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vec_cnt++; if (sel_ack !== 1'b0 || sel_cur !== 2'd0 || src_ready !== 4'b0001) begin
        err_cnt++; $display("FAIL post_reset_%0d got ack=%b cur=%0d rdy=%b want 0/0/0001", i, sel_ack, sel_cur, src_ready);
      end
    end
  endtask

`ifdef ADDR_SRC_MUX_PARITY_EN
  task automatic test_parity();
    src_valid = 4'b0001; addr_ready = 1'b1;
    src_addr[0*AW +: AW] = 14'h0007;
    step();
    vec_cnt++; if (addr_out !== 14'h0007 || addr_par !== 1'b1) begin err_cnt++; $display("FAIL par_7 got %h/%b want 0007/1", addr_out, addr_par); end
    src_addr[0*AW +: AW] = 14'h0003;
    step();
    vec_cnt++; if (addr_out !== 14'h0003 || addr_par !== 1'b0) begin err_cnt++; $display("FAIL par_3 got %h/%b want 0003/0", addr_out, addr_par); end
  endtask
`endif

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    test_reset();
    test_first_load();
    test_stream();
    test_switch();
    test_same_sel();
    test_err();
    test_reset_in_gap();
`ifdef ADDR_SRC_MUX_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
